sync_fifo_param: RTL and testbench

Single-clock, parametrised FIFO. It is the next-generation buffer for same-clock-domain paths, where the dual-clock FIFO's Gray-code pointer synchronisers are unnecessary overhead. Data width, depth, almost-full/almost-empty thresholds and read mode (standard or first-word-fall-through) are all set by parameters. It adds features the dual-clock FIFO lacks: an occupancy count, programmable almost flags, and sticky overflow/underflow error flags.

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/sync_fifo_ram.sv | 47 ++++
 rtl/sync_fifo_param.sv | 111 +++++++++++
 tb/tb_sync_fifo_param.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO: read-mode constants, clog2 and
// the threshold legality check used at elaboration.
package fifo_pkg;

    localparam int unsigned FIFO_STD  = 0;
    localparam int unsigned FIFO_FWFT = 1;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((32'd1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

    // Thresholds must satisfy AE < AF <= DEPTH with AF at least 1.
    function automatic bit thresh_ok(input int unsigned depth, input int unsigned af,
                                     input int unsigned ae);
        return (af >= 1) && (af <= depth) && (ae < af);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x DATA_W storage with one synchronous write port and one read port that is
// either registered (standard mode) or asynchronous (first-word-fall-through).
module sync_fifo_ram
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned FWFT   = FIFO_STD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is deliberately not reset; the read path never exposes stale words.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    if (FWFT == FIFO_FWFT) begin : g_async_rd
        logic unused_rd;
        assign unused_rd = ^{rst, re};
        assign rdata = mem[raddr];
    end else begin : g_reg_rd
        logic [DATA_W-1:0] rdata_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                rdata_q <= '0;
            end else if (re) begin
                rdata_q <= mem[raddr];
            end
        end
        assign rdata = rdata_q;
    end

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO: binary pointers, occupancy count, registered
// full/empty/almost flags and sticky overflow/underflow error flags.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 3,
    parameter int unsigned AF_THRESH = (2 ** ADDR_W) - 1,
    parameter int unsigned AE_THRESH = 1,
    parameter int unsigned FWFT      = FIFO_STD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned     DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] AF_LVL   = AF_THRESH[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_LVL   = AE_THRESH[ADDR_W:0];

    if (!thresh_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
        $error("sync_fifo_param: illegal thresholds, need AE_THRESH < AF_THRESH <= DEPTH");
    end

    logic [ADDR_W:0]   wr_ptr_q, rd_ptr_q, count_q, count_d;
    logic              full_q, empty_q, af_q, ae_q, ovf_q, udf_q;
    logic              wr_acc, rd_acc;
    logic [DATA_W-1:0] ram_rdata;

    // Full/empty gate acceptance strictly: no same-cycle bypass either way.
    assign wr_acc = wr_en & ~full_q;
    assign rd_acc = rd_en & ~empty_q;

    always_comb begin
        count_d = count_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            full_q  <= (count_d == FULL_CNT);
            empty_q <= (count_d == '0);
            af_q    <= (count_d >= AF_LVL);
            ae_q    <= (count_d <= AE_LVL);
            ovf_q   <= ovf_q | (wr_en & full_q);
            udf_q   <= udf_q | (rd_en & empty_q);
        end
    end

    sync_fifo_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .FWFT   (FWFT)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (wr_ptr_q[ADDR_W-1:0]),
        .wdata (wr_data),
        .re    (rd_acc),
        .raddr (rd_ptr_q[ADDR_W-1:0]),
        .rdata (ram_rdata)
    );

    if (FWFT == FIFO_FWFT) begin : g_fwft_out
        assign rd_data = empty_q ? '0 : ram_rdata;
    end else begin : g_std_out
        assign rd_data = ram_rdata;
    end

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: one standard-mode and one FWFT instance, with
// read data checked by queue-based monitors and flags checked at the falling edge.
module tb_sync_fifo_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Standard-mode instance (a_*)
    logic       a_wr_en = 1'b0, a_rd_en = 1'b0;
    logic [7:0] a_wr_data = '0, a_rd_data;
    logic       a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
    logic [2:0] a_count;

    // FWFT instance (b_*)
    logic       b_wr_en = 1'b0, b_rd_en = 1'b0;
    logic [7:0] b_wr_data = '0, b_rd_data;
    logic       b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
    logic [2:0] b_count;

    sync_fifo_param #(
        .DATA_W(8), .ADDR_W(2), .AF_THRESH(3), .AE_THRESH(1), .FWFT(0)
    ) dut_std (
        .clk(clk), .rst(rst), .wr_en(a_wr_en), .wr_data(a_wr_data), .rd_en(a_rd_en),
        .rd_data(a_rd_data), .full(a_full), .empty(a_empty), .almost_full(a_af),
        .almost_empty(a_ae), .count(a_count), .overflow(a_ovf), .underflow(a_udf)
    );

    sync_fifo_param #(
        .DATA_W(8), .ADDR_W(2), .AF_THRESH(3), .AE_THRESH(1), .FWFT(1)
    ) dut_fwft (
        .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_data(b_wr_data), .rd_en(b_rd_en),
        .rd_data(b_rd_data), .full(b_full), .empty(b_empty), .almost_full(b_af),
        .almost_empty(b_ae), .count(b_count), .overflow(b_ovf), .underflow(b_udf)
    );

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Standard mode: an accepted read presents its word just after the edge.
    always @(posedge clk) begin
        if (!rst && a_rd_en && !a_empty) begin
            #1;
            if (exp_a.size() == 0) begin
                total++;
                bad++;
                $display("FAIL std_rd_unexpected: got %0h want none", a_rd_data);
            end else begin
                chk("std_rd_data", a_rd_data, exp_a.pop_front());
            end
        end
    end

    // FWFT mode: the displayed word is the one being popped by rd_en.
    always @(posedge clk) begin
        if (!rst && b_rd_en && !b_empty) begin
            if (exp_b.size() == 0) begin
                total++;
                bad++;
                $display("FAIL fwft_rd_unexpected: got %0h want none", b_rd_data);
            end else begin
                chk("fwft_rd_data", b_rd_data, exp_b.pop_front());
            end
        end
    end

    task automatic chk_reset_a();
        chk("rst_empty", a_empty, 1);
        chk("rst_ae", a_ae, 1);
        chk("rst_full", a_full, 0);
        chk("rst_af", a_af, 0);
        chk("rst_count", a_count, 0);
        chk("rst_ovf", a_ovf, 0);
        chk("rst_udf", a_udf, 0);
        chk("rst_rd_data", a_rd_data, 0);
    endtask

    logic [7:0] wvec [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    logic       ae_v [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic       af_v [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       fu_v [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_reset_a();
        chk("fwft_rst_rd_data", b_rd_data, 0);
        chk("fwft_rst_empty", b_empty, 1);

        // Fill to full, then one write too many.
        for (int i = 0; i < 4; i++) begin
            a_wr_en   = 1'b1;
            a_wr_data = wvec[i];
            @(negedge clk);
            chk("fill_count", a_count, i + 1);
            chk("fill_ae", a_ae, ae_v[i]);
            chk("fill_af", a_af, af_v[i]);
            chk("fill_full", a_full, fu_v[i]);
        end
        a_wr_data = 8'hE5;
        @(negedge clk);
        a_wr_en = 1'b0;
        chk("ovf_set", a_ovf, 1);
        chk("ovf_count", a_count, 4);

        // Drain in order, then read while empty.
        for (int i = 0; i < 4; i++) begin
            a_rd_en = 1'b1;
            exp_a.push_back(wvec[i]);
            @(negedge clk);
        end
        a_rd_en = 1'b0;
        chk("drain_empty", a_empty, 1);
        chk("drain_count", a_count, 0);
        a_rd_en = 1'b1;
        @(negedge clk);
        a_rd_en = 1'b0;
        chk("udf_set", a_udf, 1);
        chk("udf_hold_rd_data", a_rd_data, 8'hD4);

        // Pointer wrap with concurrent write/read at count 2.
        a_wr_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a_wr_data = 8'h10 + 8'(i);
            @(negedge clk);
        end
        chk("wrap_pre_count", a_count, 2);
        a_rd_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a_wr_data = 8'h12 + 8'(i);
            exp_a.push_back(8'h10 + 8'(i));
            @(negedge clk);
            chk("wrap_count", a_count, 2);
        end
        a_wr_en = 1'b0;
        exp_a.push_back(8'h1A);
        @(negedge clk);
        exp_a.push_back(8'h1B);
        @(negedge clk);
        a_rd_en = 1'b0;
        chk("wrap_empty", a_empty, 1);

        // FWFT: word falls through without rd_en, then rd_en pops it.
        b_wr_en   = 1'b1;
        b_wr_data = 8'h5A;
        @(negedge clk);
        b_wr_en = 1'b0;
        chk("fwft_empty_drop", b_empty, 0);
        chk("fwft_show", b_rd_data, 8'h5A);
        chk("fwft_count", b_count, 1);
        @(negedge clk);
        chk("fwft_hold", b_rd_data, 8'h5A);
        b_rd_en = 1'b1;
        exp_b.push_back(8'h5A);
        @(negedge clk);
        b_rd_en = 1'b0;
        chk("fwft_pop_rd_data", b_rd_data, 0);
        chk("fwft_pop_empty", b_empty, 1);

        // Reset mid-operation with count 3 and both error flags set.
        a_wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_wr_data = 8'h31 + 8'(i);
            @(negedge clk);
        end
        chk("pre_rst_count", a_count, 3);
        chk("pre_rst_ovf", a_ovf, 1);
        chk("pre_rst_udf", a_udf, 1);
        rst       = 1'b1;
        a_wr_data = 8'h77;
        @(negedge clk);
        rst     = 1'b0;
        a_wr_en = 1'b0;
        chk_reset_a();
        @(negedge clk);
        chk("post_rst_count", a_count, 0);
        chk("post_rst_empty", a_empty, 1);

        chk("std_queue_drained", exp_a.size(), 0);
        chk("fwft_queue_drained", exp_b.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
